// File: rtl/alu_unit.sv
// alu_unit: execution end of the reservation-station-to-ALU path.
// Computes one 32-bit result per issued instruction and queues it in a small
// FIFO that presents the oldest result to the CDB arbiter until granted.
// rob_clear flushes the queue; rdy_in low freezes every piece of state.
// Optional build macro ALU_STAT_EN adds the stat_done / stat_stall counters.
module alu_unit #(
    parameter int RS_TYPE_BIT  = 4,
    parameter int ROB_SIZE_BIT = 4,
    parameter int RES_DEPTH    = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    alu_input,
    input  logic [RS_TYPE_BIT-1:0]  arith_type,
    input  logic [31:0]             r1_val,
    input  logic [31:0]             r2_val,
    input  logic [ROB_SIZE_BIT-1:0] inst_rob_id,
    output logic                    alu_full,
    output logic                    cdb_valid,
    output logic [31:0]             cdb_value,
    output logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
    input  logic                    cdb_grant
`ifdef ALU_STAT_EN
    ,
    output logic [31:0]             stat_done,
    output logic [31:0]             stat_stall
`endif
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;

    // Pure ALU datapath; unknown op codes yield zero.
    function automatic logic [31:0] alu_compute(
        input logic [RS_TYPE_BIT-1:0] op,
        input logic [31:0]            a,
        input logic [31:0]            b
    );
        logic [31:0] res;
        case (op)
            RS_TYPE_BIT'(0):  res = a + b;
            RS_TYPE_BIT'(1):  res = a - b;
            RS_TYPE_BIT'(2):  res = a & b;
            RS_TYPE_BIT'(3):  res = a | b;
            RS_TYPE_BIT'(4):  res = a ^ b;
            RS_TYPE_BIT'(5):  res = a << b[4:0];
            RS_TYPE_BIT'(6):  res = a >> b[4:0];
            RS_TYPE_BIT'(7):  res = $unsigned($signed(a) >>> b[4:0]);
            RS_TYPE_BIT'(8):  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(9):  res = (a < b) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(10): res = (a == b) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(11): res = (a != b) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(12): res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(13): res = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(14): res = (a < b) ? 32'd1 : 32'd0;
            RS_TYPE_BIT'(15): res = (a >= b) ? 32'd1 : 32'd0;
            default:          res = 32'd0;
        endcase
        return res;
    endfunction

    logic [31:0]             val_q [RES_DEPTH];
    logic [31:0]             val_d [RES_DEPTH];
    logic [ROB_SIZE_BIT-1:0] rob_q [RES_DEPTH];
    logic [ROB_SIZE_BIT-1:0] rob_d [RES_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    full_q, full_d;
    logic                    valid_q, valid_d;
    logic [31:0]             value_q, value_d;
    logic [ROB_SIZE_BIT-1:0] head_rob_q, head_rob_d;
    logic                    push_s;
    logic                    pop_s;
    logic                    flush_s;

    assign alu_full   = full_q;
    assign cdb_valid  = valid_q;
    assign cdb_value  = value_q;
    assign cdb_rob_id = head_rob_q;

    // Next-state for FIFO storage, pointers, count and the registered head view.
    always_comb begin
        push_s  = rdy_in && alu_input && !full_q && !rob_clear;
        pop_s   = rdy_in && valid_q && cdb_grant && !rob_clear;
        flush_s = rdy_in && rob_clear;
        val_d   = val_q;
        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_s) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                val_d[tail_q] = alu_compute(arith_type, r1_val, r2_val);
                rob_d[tail_q] = inst_rob_id;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end
        full_d     = (count_d == CNT_W'(RES_DEPTH));
        valid_d    = (count_d != {CNT_W{1'b0}});
        value_d    = val_d[head_d];
        head_rob_d = rob_d[head_d];
    end

    // State registers with asynchronous active-low reset clearing every entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                val_q[i] <= 32'd0;
                rob_q[i] <= {ROB_SIZE_BIT{1'b0}};
            end
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            value_q    <= 32'd0;
            head_rob_q <= {ROB_SIZE_BIT{1'b0}};
        end else begin
            val_q      <= val_d;
            rob_q      <= rob_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            head_rob_q <= head_rob_d;
        end
    end

`ifdef ALU_STAT_EN
    logic [31:0] done_q;
    logic [31:0] stall_q;

    assign stat_done  = done_q;
    assign stat_stall = stall_q;

    // Activity counters; they survive rob_clear and wrap naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            done_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (pop_s) begin
                done_q <= done_q + 32'd1;
            end else begin
                done_q <= done_q;
            end
            if (rdy_in && valid_q && !cdb_grant) begin
                stall_q <= stall_q + 32'd1;
            end else begin
                stall_q <= stall_q;
            end
        end
    end
`endif

endmodule
